// File: rtl/fir_sample_driver_if.sv
`default_nettype none
//============================================================================
// fir_sample_driver_if : sample stream, FIR run/busy and result stream bundle
// Rev 1.0
//============================================================================
interface fir_sample_driver_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              fir_run;
    logic [DATA_W-1:0] fir_sample;
    logic              fir_busy;
    logic [DATA_W-1:0] fir_result;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    // master is the driver side; slave is the environment (source, filter, sink)
    modport master (
        input  in_valid, in_data,
        output in_ready,
        output fir_run, fir_sample,
        input  fir_busy, fir_result,
        output out_valid, out_data,
        input  out_ready
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        input  fir_run, fir_sample,
        output fir_busy, fir_result,
        input  out_valid, out_data,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fir_sample_driver.sv
`default_nettype none
//============================================================================
// fir_sample_driver : one-at-a-time FIR run/busy initiator with result FIFO
// Rev 1.0
//============================================================================
module fir_sample_driver #(
    parameter int DATA_W         = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    fir_sample_driver_if.master bus,
    output logic                err_timeout,
    input  wire logic           err_clr
);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;

    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_AW:0]   c_FULL     = (c_AW + 1)'(FIFO_DEPTH);

    logic [1:0]        r_state;
    logic [c_CW-1:0]   r_wait_cnt;
    logic [DATA_W-1:0] r_sample;
    logic              r_err;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;

    logic w_in_ready;
    logic w_accept;
    logic w_push;
    logic w_timeout;
    logic w_pop;

    // The ~fir_busy term keeps a filter that is still finishing after a reset
    // from being handed a new sample.
    always_comb begin
        w_in_ready = (r_state == c_IDLE) && (r_count < c_FULL) && !bus.fir_busy;
        w_accept   = bus.in_valid && w_in_ready;
        // busy is not yet meaningful in the first WAIT cycle (counter == 0)
        w_push     = (r_state == c_WAIT) && (r_wait_cnt != '0) && !bus.fir_busy;
        w_timeout  = (r_state == c_WAIT) && !w_push && (r_wait_cnt == c_CNT_LAST);
        w_pop      = (r_count != '0) && bus.out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_wait_cnt <= '0;
            r_sample   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_sample <= bus.in_data;
                        r_state  <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= c_WAIT;
                end
                c_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (w_push || w_timeout) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.fir_result;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A timeout in the same cycle as err_clr leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.fir_run    = (r_state == c_ISSUE);
    assign bus.fir_sample = r_sample;
    assign bus.out_valid  = (r_count != '0);
    assign bus.out_data   = r_mem[r_rd_ptr];
    assign err_timeout    = r_err;

endmodule
`default_nettype wire
